// File: rtl/sink_pkg.sv
// Shared types and constants for the virtual-channel flit sink.
package sink_pkg;

    // Sink verdict FSM states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_FAIL = 2'd2
    } sink_state_e;

    // Ready-generation policies
    typedef enum logic [1:0] {
        RDY_ALWAYS = 2'd0,
        RDY_DUTY   = 2'd1,
        RDY_LFSR   = 2'd2
    } rdy_mode_e;

    // Bit positions inside err_code_o
    localparam int ERR_VC  = 0;
    localparam int ERR_SEQ = 1;
    localparam int ERR_OVF = 2;

    // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/sink_ready_gen.sv
// Flop-only ready generator: always-on, duty-cycle or pseudo-random backpressure.
module sink_ready_gen
    import sink_pkg::*;
#(
    parameter int          RDY_MODE   = 1,
    parameter int          RDY_PERIOD = 16,
    parameter int          RDY_ON     = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rstn,
    output logic ready_o
);

    localparam int PW = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;

    logic          run_q;
    logic [PW-1:0] cnt_q;
    logic [15:0]   lfsr_q;
    logic          ready_s;

    // Run flag, duty-cycle counter and LFSR all free-run from reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            lfsr_q <= SEED;
        end else begin
            run_q  <= 1'b1;
            cnt_q  <= (cnt_q == PW'(RDY_PERIOD - 1)) ? '0 : cnt_q + PW'(1);
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    // Ready is a pure function of the flops above, never of any input
    always_comb begin
        ready_s = 1'b0;
        case (RDY_MODE)
            int'(RDY_ALWAYS): ready_s = run_q;
            int'(RDY_DUTY):   ready_s = run_q & (int'(cnt_q) < RDY_ON);
            int'(RDY_LFSR):   ready_s = run_q & lfsr_q[0];
            default:          ready_s = 1'b0;
        endcase
    end

    assign ready_o = ready_s;

endmodule

// File: rtl/vc_flit_sink.sv
// Traffic sink: counts flits per virtual channel, checks sequence numbers,
// and reports a sticky DONE/FAIL verdict.
`ifndef VN
`define VN 2
`endif
`ifndef DW
`define DW 32
`endif

module vc_flit_sink
    import sink_pkg::*;
#(
    parameter int          VN         = `VN,
    parameter int          DW         = `DW,
    parameter int          EXPECT     = 1000,
    parameter int          RDY_MODE   = 1,
    parameter int          RDY_PERIOD = 16,
    parameter int          RDY_ON     = 2,
    parameter int          SW         = 8,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         CW         = $clog2(EXPECT + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [VN-1:0]    vc_i,
    input  logic [DW-1:0]    data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [VN*CW-1:0] cnt_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       err_code_o
);

    logic          ready_s;
    logic          accept_s;
    logic          onehot_s;
    logic          all_full_s;
    logic [2:0]    err_n_s;
    logic [CW-1:0] cnt_n_s   [VN];
    logic [SW-1:0] seq_n_s   [VN];
    logic [CW-1:0] cnt_q     [VN];
    logic [SW-1:0] exp_seq_q [VN];
    logic [2:0]    err_code_q;
    sink_state_e   state_q;
    logic          done_q;
    logic          err_q;

    sink_ready_gen #(
        .RDY_MODE  (RDY_MODE),
        .RDY_PERIOD(RDY_PERIOD),
        .RDY_ON    (RDY_ON),
        .SEED      (SEED)
    ) u_ready_gen (
        .clk    (clk),
        .rstn   (rstn),
        .ready_o(ready_s)
    );

    assign accept_s = valid_i & ready_s;

    // Next counts, expected sequence numbers and error bits for this accept
    always_comb begin
        onehot_s = (vc_i != '0) && ((vc_i & (vc_i - VN'(1))) == '0);
        err_n_s  = err_code_q;
        for (int v = 0; v < VN; v++) begin
            cnt_n_s[v] = cnt_q[v];
            seq_n_s[v] = exp_seq_q[v];
        end
        if (accept_s) begin
            if (!onehot_s) begin
                err_n_s[ERR_VC] = 1'b1;
            end else begin
                for (int v = 0; v < VN; v++) begin
                    if (vc_i[v]) begin
                        if (data_i[SW-1:0] != exp_seq_q[v]) begin
                            err_n_s[ERR_SEQ] = 1'b1;
                        end else begin
                            err_n_s[ERR_SEQ] = err_n_s[ERR_SEQ];
                        end
                        // Resync to the received number so one gap reports once
                        seq_n_s[v] = data_i[SW-1:0] + SW'(1);
                        if (cnt_q[v] == CW'(EXPECT)) begin
                            err_n_s[ERR_OVF] = 1'b1;
                        end else begin
                            cnt_n_s[v] = cnt_q[v] + CW'(1);
                        end
                    end else begin
                        cnt_n_s[v] = cnt_q[v];
                    end
                end
            end
        end else begin
            err_n_s = err_code_q;
        end
        all_full_s = 1'b1;
        for (int v = 0; v < VN; v++) begin
            if (cnt_n_s[v] != CW'(EXPECT)) begin
                all_full_s = 1'b0;
            end else begin
                all_full_s = all_full_s;
            end
        end
    end

    // Per-VC counters, expected sequence numbers and sticky error code
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < VN; v++) begin
                cnt_q[v]     <= '0;
                exp_seq_q[v] <= '0;
            end
            err_code_q <= 3'b000;
        end else begin
            for (int v = 0; v < VN; v++) begin
                cnt_q[v]     <= cnt_n_s[v];
                exp_seq_q[v] <= seq_n_s[v];
            end
            err_code_q <= err_n_s;
        end
    end

    // Verdict FSM; an error in the completing cycle takes priority over DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (err_n_s != 3'b000) begin
                        state_q <= ST_FAIL;
                        done_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (all_full_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (err_n_s != 3'b000) begin
                        state_q <= ST_FAIL;
                        done_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    state_q <= ST_FAIL;
                    done_q  <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_FAIL;
                    done_q  <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    // Flatten the per-VC counters onto the output bus
    always_comb begin
        cnt_o = '0;
        for (int v = 0; v < VN; v++) begin
            cnt_o[v*CW +: CW] = cnt_q[v];
        end
    end

    assign ready_o    = ready_s;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_vc_flit_sink.sv
// Directed bench for vc_flit_sink: table-driven mode-0 vectors, plus
// duty-cycle and LFSR ready sequences with a mid-stream reset.
module tb_vc_flit_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- mode 0 instance (VN=2, EXPECT=4, CW=3)
    logic        rstn0 = 1'b0;
    logic [1:0]  vc0   = 2'b00;
    logic [15:0] data0 = 16'h0000;
    logic        valid0 = 1'b0;
    logic        ready0, done0, err0;
    logic [5:0]  cnt0;
    logic [2:0]  code0;

    vc_flit_sink #(.VN(2), .DW(16), .EXPECT(4), .RDY_MODE(0), .SW(8)) d_m0 (
        .clk(clk), .rstn(rstn0), .vc_i(vc0), .data_i(data0), .valid_i(valid0),
        .ready_o(ready0), .cnt_o(cnt0), .done_o(done0), .err_o(err0), .err_code_o(code0));

    // ---------------- mode 1 instance (16/2 duty cycle, CW=10)
    logic        rstn1 = 1'b0;
    logic [1:0]  vc1   = 2'b01;
    logic [15:0] data1 = 16'h0000;
    logic        valid1 = 1'b0;
    logic        ready1, done1, err1;
    logic [19:0] cnt1;
    logic [2:0]  code1;

    vc_flit_sink #(.VN(2), .DW(16), .EXPECT(1000), .RDY_MODE(1), .RDY_PERIOD(16), .RDY_ON(2), .SW(8)) d_m1 (
        .clk(clk), .rstn(rstn1), .vc_i(vc1), .data_i(data1), .valid_i(valid1),
        .ready_o(ready1), .cnt_o(cnt1), .done_o(done1), .err_o(err1), .err_code_o(code1));

    // ---------------- mode 2 instance (LFSR ready)
    logic        rstn2 = 1'b0;
    logic [1:0]  vc2   = 2'b01;
    logic [15:0] data2 = 16'h0000;
    logic        valid2 = 1'b0;
    logic        ready2, done2, err2;
    logic [19:0] cnt2;
    logic [2:0]  code2;

    vc_flit_sink #(.VN(2), .DW(16), .EXPECT(1000), .RDY_MODE(2), .SW(8), .SEED(16'hACE1)) d_m2 (
        .clk(clk), .rstn(rstn2), .vc_i(vc2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .cnt_o(cnt2), .done_o(done2), .err_o(err2), .err_code_o(code2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        logic       valid;
        logic [1:0] vc;
        logic [7:0] data;
        int         c0;
        int         c1;
        int         done;
        int         err;
        int         code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic valid, logic [1:0] vc, logic [7:0] data,
                                int c0, int c1, int done, int err, int code);
        vec_t r;
        r.rst = rst; r.valid = valid; r.vc = vc; r.data = data;
        r.c0 = c0; r.c1 = c1; r.done = done; r.err = err; r.code = code;
        return r;
    endfunction

    function automatic logic [15:0] step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    initial begin
        // rst valid vc data   c0 c1 done err code
        tbl.push_back(mk(1, 0, 2'b00, 8'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd1, 2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd1, 2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 8'd7, 2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd2, 3, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd2, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd3, 4, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd3, 4, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 8'd0, 4, 4, 1, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd4, 4, 4, 0, 1, 4));
        tbl.push_back(mk(0, 0, 2'b00, 8'd0, 4, 4, 0, 1, 4));
        tbl.push_back(mk(1, 0, 2'b00, 8'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 8'd0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 2'b00, 8'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd3, 3, 0, 0, 1, 2));
        tbl.push_back(mk(0, 1, 2'b10, 8'd0, 3, 1, 0, 1, 2));
        tbl.push_back(mk(1, 0, 2'b00, 8'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd1, 2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd1, 2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd2, 3, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd2, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 8'd3, 4, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'd5, 4, 4, 0, 1, 2));
        tbl.push_back(mk(0, 0, 2'b00, 8'd0, 4, 4, 0, 1, 2));

        // ---------------- mode 0 table
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                rstn0  = 1'b0;
                valid0 = 1'b1;
                vc0    = 2'b01;
                data0  = 16'h0000;
                #1;
                chk($sformatf("r%0d rst ready", i), int'(ready0), 0);
            end else begin
                @(negedge clk);
                valid0 = tbl[i].valid;
                vc0    = tbl[i].vc;
                data0  = {8'h00, tbl[i].data};
                @(posedge clk);
                #1;
                chk($sformatf("r%0d ready", i), int'(ready0), 1);
            end
            chk($sformatf("r%0d cnt0", i), int'(cnt0[2:0]), tbl[i].c0);
            chk($sformatf("r%0d cnt1", i), int'(cnt0[5:3]), tbl[i].c1);
            chk($sformatf("r%0d done", i), int'(done0), tbl[i].done);
            chk($sformatf("r%0d err", i), int'(err0), tbl[i].err);
            chk($sformatf("r%0d code", i), int'(code0), tbl[i].code);
            if (i == 18) begin
                chk("exp_seq0 after gap", int'(d_m0.exp_seq_q[0]), 4);
            end
            if (tbl[i].rst) begin
                // a flit held during reset and through the release edge is not counted
                @(posedge clk);
                #1;
                chk($sformatf("r%0d cnt in rst", i), int'(cnt0), 0);
                @(negedge clk);
                rstn0  = 1'b1;
                valid0 = 1'b0;
                chk($sformatf("r%0d ready pre-run", i), int'(ready0), 0);
                @(posedge clk);
                #1;
                chk($sformatf("r%0d ready run", i), int'(ready0), 1);
            end
        end

        // ---------------- mode 1: duty cycle with valid held high
        begin
            int cm;
            bit rm;
            int acc;
            int at16;
            int at32;
            cm = 0; rm = 1'b0; acc = 0; at16 = 0; at32 = 0;
            @(negedge clk);
            rstn1  = 1'b1;
            valid1 = 1'b1;
            for (int c = 1; c <= 48; c++) begin
                data1 = 16'(acc % 256);
                @(posedge clk);
                if (rm && (cm < 2)) acc++;
                rm = 1'b1;
                cm = (cm + 1) % 16;
                #1;
                chk($sformatf("duty ready c%0d", c), int'(ready1), (cm < 2) ? 1 : 0);
                chk($sformatf("duty cnt c%0d", c), int'(cnt1[9:0]), acc);
                if (c == 16) at16 = int'(cnt1[9:0]);
                if (c == 32) at32 = int'(cnt1[9:0]);
                @(negedge clk);
            end
            chk("duty accepts per 16", at32 - at16, 2);
            chk("duty no error", int'(err1), 0);
        end

        // ---------------- mode 2: LFSR sequence, mid-stream reset, replay
        begin
            logic [15:0] lm;
            bit          first [40];
            lm = 16'hACE1;
            @(negedge clk);
            rstn2  = 1'b1;
            valid2 = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                lm = step(lm);
                #1;
                chk($sformatf("lfsr1 c%0d", c), int'(ready2), int'(lm[0]));
                first[c] = ready2;
                data2 = data2 + 16'd1;
            end
            chk("lfsr run accepted some", (cnt2[9:0] != 10'd0) ? 1 : 0, 1);
            #2;
            rstn2 = 1'b0;
            #1;
            chk("lfsr rst ready", int'(ready2), 0);
            chk("lfsr rst cnt", int'(cnt2), 0);
            chk("lfsr rst done", int'(done2), 0);
            chk("lfsr rst err", int'(err2), 0);
            chk("lfsr rst code", int'(code2), 0);
            @(posedge clk);
            #1;
            chk("lfsr cnt held in rst", int'(cnt2), 0);
            @(negedge clk);
            rstn2 = 1'b1;
            lm = 16'hACE1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                lm = step(lm);
                #1;
                chk($sformatf("lfsr2 model c%0d", c), int'(ready2), int'(lm[0]));
                chk($sformatf("lfsr2 replay c%0d", c), int'(ready2), int'(first[c]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
